// File: rtl/debouncer_multi.sv
// ============================================================================
// Module      : debouncer_multi
// Description : Multi-channel input debouncer. Each channel runs a two-flop
//               synchroniser, a stability counter enabled by 'tick', and
//               drives a debounced level plus one-clock rise/fall strobes.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous active-high reset
//               tick - counter enable strobe (tie high to count every clk)
//               in   - raw asynchronous inputs, one bit per channel
//               out  - debounced levels
//               rise - one-clock pulse when out[i] goes 0->1
//               fall - one-clock pulse when out[i] goes 1->0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debouncer_multi #(
    parameter int                  CHANNELS      = 4,
    parameter int                  STABLE_CYCLES = 255,
    parameter logic [CHANNELS-1:0] RESET_VALUE   = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    localparam int               CNT_W     = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    // Channels share nothing but clk, rst and tick.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             r_s0;   // first synchroniser stage, may go metastable
        logic             r_s1;   // second stage, the only reader of r_s0
        logic [CNT_W-1:0] r_cnt;  // ticks the synchronised level has held
        logic             r_out;
        logic             r_rise;
        logic             r_fall;

        logic             w_chg;
        logic             w_sat;
        logic             w_upd;

        // A difference between the stages means the level is still moving.
        assign w_chg = r_s0 ^ r_s1;
        assign w_sat = (r_cnt == c_cnt_max);
        // Only a completed window on a level different from out produces an
        // update; a glitch that returns to the current level is absorbed.
        assign w_upd = w_sat && !w_chg && (r_s1 != r_out);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_s0   <= RESET_VALUE[i];
                r_s1   <= RESET_VALUE[i];
                r_cnt  <= '0;
                r_out  <= RESET_VALUE[i];
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_s0 <= in[i];
                r_s1 <= r_s0;

                // A change restarts the window even on non-tick cycles;
                // otherwise count ticks and saturate instead of wrapping.
                if (w_chg) begin
                    r_cnt <= '0;
                end else if (tick && !w_sat) begin
                    r_cnt <= r_cnt + c_cnt_one;
                end

                // Strobes default low so each lasts exactly one clock.
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                if (w_upd) begin
                    r_out  <= r_s1;
                    r_rise <= r_s1;
                    r_fall <= ~r_s1;
                end
            end
        end

        assign out[i]  = r_out;
        assign rise[i] = r_rise;
        assign fall[i] = r_fall;
    end

endmodule

`default_nettype wire

// File: tb/tb_debouncer_multi.sv
// ============================================================================
// Module      : tb_debouncer_multi
// Description : Self-checking bench for debouncer_multi (4 channels, window of
//               4 ticks). Table-driven vectors, hand-written corner-case
//               sequences, and a randomized run against a history-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debouncer_multi;

    localparam int         C_CH = 4;
    localparam int         C_S  = 4;
    localparam logic [3:0] C_RV = 4'b0000;

    logic       clk;
    logic       tb_rst;
    logic       tb_tick;
    logic [3:0] tb_in;
    logic [3:0] tb_out;
    logic [3:0] tb_rise;
    logic [3:0] tb_fall;

    debouncer_multi #(
        .CHANNELS      (C_CH),
        .STABLE_CYCLES (C_S),
        .RESET_VALUE   (C_RV)
    ) dut (
        .clk  (clk),
        .rst  (tb_rst),
        .tick (tb_tick),
        .in   (tb_in),
        .out  (tb_out),
        .rise (tb_rise),
        .fall (tb_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: keeps the full history of sampled inputs and ticks
    // since reset. At edge n a channel takes the synchronised level if that
    // level has been unchanged, looking backwards, long enough to collect
    // C_S ticks (ticks on the edge of a change do not count).
    // xh[k] holds the input seen at edge k-1; xh[0], xh[1] are the reset
    // contents of the two synchroniser stages. th[n] is tick at edge n.
    // ------------------------------------------------------------------
    logic [3:0] xh[$];
    bit         th[$];
    logic [3:0] m_out, m_rise, m_fall;

    task automatic model_reset();
        xh.delete();
        th.delete();
        xh.push_back(C_RV);
        xh.push_back(C_RV);
        th.push_back(1'b0);
        m_out  = C_RV;
        m_rise = '0;
        m_fall = '0;
    endtask

    task automatic model_step();
        int n;
        int cnt;
        bit ok;
        n      = th.size() - 1;
        m_rise = '0;
        m_fall = '0;
        for (int c = 0; c < C_CH; c++) begin
            ok = 1'b0;
            if (xh[n][c] == xh[n-1][c]) begin
                cnt = 0;
                for (int j = n - 1; j >= 1; j--) begin
                    if (xh[j][c] != xh[j-1][c]) break;
                    if (th[j]) cnt++;
                    if (cnt == C_S) begin
                        ok = 1'b1;
                        break;
                    end
                end
            end
            if (ok && (xh[n-1][c] != m_out[c])) begin
                m_out[c]  = xh[n-1][c];
                m_rise[c] = xh[n-1][c];
                m_fall[c] = ~xh[n-1][c];
            end
        end
    endtask

    // Per-channel strobe statistics for the hand-written sequences.
    int edge_no;
    int rise_cnt[4];
    int fall_cnt[4];
    int first_rise[4];
    int first_fall[4];
    bit rand_mode = 1'b0;

    task automatic clear_stats();
        edge_no = 0;
        for (int c = 0; c < C_CH; c++) begin
            rise_cnt[c]   = 0;
            fall_cnt[c]   = 0;
            first_rise[c] = -1;
            first_fall[c] = -1;
        end
    endtask

    // Apply inputs for the next edge, then sample 1 time unit after it.
    task automatic cycle(input logic [3:0] vin, input logic vt);
        tb_in   = vin;
        tb_tick = vt;
        @(posedge clk);
        xh.push_back(vin);
        th.push_back(vt);
        model_step();
        #1;
        edge_no++;
        for (int c = 0; c < C_CH; c++) begin
            if (tb_rise[c]) begin
                rise_cnt[c]++;
                if (first_rise[c] < 0) first_rise[c] = edge_no;
            end
            if (tb_fall[c]) begin
                fall_cnt[c]++;
                if (first_fall[c] < 0) first_fall[c] = edge_no;
            end
        end
        if (rand_mode) begin
            check("rand_out",  tb_out,  m_out);
            check("rand_rise", tb_rise, m_rise);
            check("rand_fall", tb_fall, m_fall);
        end
    endtask

    // Called 1 unit after an edge: asserts reset between edges, holds it for
    // two edges and releases it between edges.
    task automatic do_reset(input logic [3:0] vin);
        tb_in = vin;
        #3 tb_rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 tb_rst = 1'b0;
        model_reset();
        clear_stats();
    endtask

    typedef struct {
        logic [3:0] vin;
        logic       vtick;
        logic [3:0] eout;
        logic [3:0] erise;
        logic [3:0] efall;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int reps, input logic [3:0] vin, input logic [3:0] eout,
                       input logic [3:0] erise, input logic [3:0] efall);
        vec_t v;
        v.vin   = vin;
        v.vtick = 1'b1;
        v.eout  = eout;
        v.erise = erise;
        v.efall = efall;
        for (int k = 0; k < reps; k++) vecs.push_back(v);
    endtask

    logic [3:0] cur;
    int         drop_edge;
    logic [3:0] acc;

    initial begin
        tb_rst  = 1'b0;
        tb_tick = 1'b1;
        tb_in   = 4'b0000;
        clear_stats();
        model_reset();

        // Single rise on ch0, its fall, all-channel rise, then a mixed fall.
        add(6, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
        add(1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        add(6, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(6, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b1111, 4'b1111, 4'b1111, 4'b0000);
        add(1, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        add(6, 4'b0101, 4'b1111, 4'b0000, 4'b0000);
        add(1, 4'b0101, 4'b0101, 4'b0000, 4'b1010);
        add(1, 4'b0101, 4'b0101, 4'b0000, 4'b0000);

        // Asynchronous reset before any clock edge.
        #2 tb_rst = 1'b1;
        #1;
        check("reset_out",  tb_out,  C_RV);
        check("reset_rise", tb_rise, 4'b0000);
        check("reset_fall", tb_fall, 4'b0000);
        repeat (2) @(posedge clk);
        #3 tb_rst = 1'b0;
        model_reset();
        clear_stats();

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].vin, vecs[i].vtick);
            check($sformatf("vec%0d_out", i),  tb_out,  vecs[i].eout);
            check($sformatf("vec%0d_rise", i), tb_rise, vecs[i].erise);
            check($sformatf("vec%0d_fall", i), tb_fall, vecs[i].efall);
        end

        // Glitches on ch1: 3- and 5-clk pulses are too short; 6 clk suffices.
        do_reset(4'b0000);
        repeat (3)  cycle(4'b0010, 1'b1);
        repeat (12) cycle(4'b0000, 1'b1);
        check("glitch3_rise", rise_cnt[1], 0);
        check("glitch3_fall", fall_cnt[1], 0);
        repeat (5)  cycle(4'b0010, 1'b1);
        repeat (12) cycle(4'b0000, 1'b1);
        check("glitch5_rise", rise_cnt[1], 0);
        check("glitch5_fall", fall_cnt[1], 0);
        repeat (6)  cycle(4'b0010, 1'b1);
        repeat (12) cycle(4'b0000, 1'b1);
        check("pulse6_rise", rise_cnt[1], 1);
        check("pulse6_fall", fall_cnt[1], 1);
        check("pulse6_other_rise", rise_cnt[0] + rise_cnt[2] + rise_cnt[3], 0);

        // Tick every 3rd edge on ch2: window is 4 ticks, not 4 clocks.
        do_reset(4'b0000);
        for (int e = 1; e <= 12; e++) cycle(4'b0100, (e % 3) == 0);
        check("tick_gate_early_out", tb_out[2], 1'b0);
        cycle(4'b0100, 1'b0);
        check("tick_gate_rise_edge", first_rise[2], 13);
        // Drop, then a one-clk glitch on two non-tick edges restarts the count.
        for (int e = 14; e <= 45; e++) cycle((e == 25) ? 4'b0100 : 4'b0000, (e % 3) == 0);
        check("tick_gate_fall_edge", first_fall[2], 40);
        check("tick_gate_fall_cnt",  fall_cnt[2], 1);

        // Long hold on ch3 then a drop: one rise, one fall, S+2 after drop.
        do_reset(4'b0000);
        repeat (1000) cycle(4'b1000, 1'b1);
        drop_edge = edge_no + 1;
        repeat (20) cycle(4'b0000, 1'b1);
        check("sat_rise_cnt", rise_cnt[3], 1);
        check("sat_fall_cnt", fall_cnt[3], 1);
        check("sat_fall_delay", first_fall[3] - drop_edge, C_S + 2);

        // Reset mid-count with outputs high.
        do_reset(4'b0000);
        repeat (8) cycle(4'b1111, 1'b1);
        check("pre_rst_out", tb_out, 4'b1111);
        repeat (3) cycle(4'b0000, 1'b1);
        tb_in = 4'b1111;
        #3 tb_rst = 1'b1;
        #1;
        check("rst_async_out",  tb_out,  C_RV);
        check("rst_async_rise", tb_rise, 4'b0000);
        check("rst_async_fall", tb_fall, 4'b0000);
        acc = 4'b0000;
        repeat (2) begin
            @(posedge clk);
            #1;
            acc = acc | tb_rise | tb_fall | tb_out;
        end
        check("rst_hold_quiet", acc, 4'b0000);
        #2 tb_rst = 1'b0;
        model_reset();
        clear_stats();
        acc = 4'b0000;
        repeat (6) begin
            cycle(4'b1111, 1'b1);
            acc = acc | tb_rise | tb_fall;
        end
        check("rst_exit_no_early_strobe", acc, 4'b0000);
        cycle(4'b1111, 1'b1);
        check("rst_exit_rise", tb_rise, 4'b1111);

        // Randomized run against the model.
        do_reset(4'b0000);
        rand_mode = 1'b1;
        cur = 4'b0000;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < C_CH; c++)
                if ($urandom_range(7) == 0) cur[c] = ~cur[c];
            cycle(cur, $urandom_range(3) != 0);
        end
        rand_mode = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
- Parametrised, multi-channel successor to the single-bit button debouncer.
- Each channel synchronises an asynchronous input, filters it against a programmable stability window, and drives a debounced level plus one-cycle rise/fall strobes.
- An optional tick input scales the window, for example to ms-range button filtering from a fast clk.
- Sits between board switches/buttons and the control FSMs.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
STABLE_CYCLES, 255, counted ticks an input must hold before out follows it (>=1)
RESET_VALUE, 0 (CHANNELS bits), value of out after reset, per channel
Local, not overridable: CNT_W = $clog2(STABLE_CYCLES+1)

Ports:
clk    input   1         system clock, all flops on rising edge
rst    input   1         asynchronous, active-high reset
tick   input   1         counter enable strobe; tie 1 to count every clk
in     input   CHANNELS  raw asynchronous inputs
out    output  CHANNELS  debounced levels
rise   output  CHANNELS  one-clk pulse when out[i] goes 0->1
fall   output  CHANNELS  one-clk pulse when out[i] goes 1->0

Behaviour:
- Reset. rst high clears immediately, without waiting for clk, and holds while asserted:
  - sync stages s0[i], s1[i] <= RESET_VALUE[i]
  - cnt[i] <= 0
  - out <= RESET_VALUE; rise, fall <= 0
- Reset mid-filter discards any partial count. No pulses are emitted on reset entry or exit.
- Per channel, fully independent; no shared state between channels.
- Synchroniser: s0 <= in; s1 <= s0 every clk, regardless of tick.
- Change detect: chg = s0 ^ s1.
- Counter, priority order:
  - chg=1: cnt <= 0. This applies even when tick=0; a change always wins over tick.
  - chg=0 and tick=1 and cnt<STABLE_CYCLES: cnt <= cnt+1.
  - Otherwise cnt holds. The counter saturates at STABLE_CYCLES and never wraps.
- Output update: when cnt==STABLE_CYCLES and chg=0 and s1!=out:
  - out <= s1
  - rise <= s1, fall <= ~s1
- rise/fall are registered, high for exactly one clk, then cleared. At most one of rise[i], fall[i] is high in any cycle.
- Latency with tick=1: input stable before edge k => cnt=0 at edge k+1, reaches STABLE_CYCLES at edge k+1+STABLE_CYCLES, out and strobe updated at edge k+2+STABLE_CYCLES.
- Latency with tick gated: the window is STABLE_CYCLES ticks, not clocks.
- Glitch: any input change, including one shorter than the window, restarts the count. out is unchanged unless the new level completes a full window.
- Saturated and stable: no further strobes and out holds, however long the input stays constant.
- Returning to the current out level after a glitch: the count completes, but s1==out, so out and the strobes stay unchanged.
- Simultaneous events on different channels are handled in the same cycle. Multiple rise/fall bits may be set together.
- Metastability: only s0 may go metastable. Nothing except s1 samples s0.

Test Plan:
1. CHANNELS=4, STABLE_CYCLES=4, tick=1. Raise in[0] before edge 1 and hold -> out[0]=1 and rise[0]=1 after edge 7; rise[0]=0 after edge 8; other channels remain 0.
2. Glitch: in[1] high for 3 clk then low, STABLE_CYCLES=4 -> out[1] stays 0; no rise[1]/fall[1] ever. Repeat with a 5-clk pulse -> rise[1] only if the level survives the full window.
3. Tick gating: tick high every 3rd clk, STABLE_CYCLES=4, in[2] 0->1 held -> out[2] rises only after 4 ticks post-settling, not 4 clk. Toggle in[2] while tick=0 -> count restarts.
4. Falling edge plus saturation: hold in[3]=1 for 1000 clk, then drop to 0 -> exactly one rise[3] and one fall[3] overall; fall[3] comes STABLE_CYCLES+2 clk after the drop.
5. Reset: assert rst mid-count on all channels, asynchronously between edges -> out=RESET_VALUE immediately, no strobes. Release with inputs high -> full window restarts before rise.
6. Concurrent channels: in=4'b1111 at once -> rise=4'b1111 in a single cycle. Then in=4'b0101 -> fall=4'b1010 in a single cycle, rise=0.
